// File: rtl/armleocpu_tlb_way_if.sv
// armleocpu_tlb_way_if: command, lookup and write bundle between the parent TLB and one way
interface armleocpu_tlb_way_if;
  logic        enable;
  logic        invalidate;
  logic        resolve;
  logic [19:0] virtual_address;
  logic        miss;
  logic        done;
  logic [7:0]  accesstag_r;
  logic [21:0] phys_r;
  logic        write;
  logic [19:0] virtual_address_w;
  logic [7:0]  accesstag_w;
  logic [21:0] phys_w;
  modport master (
    output enable, invalidate, resolve, virtual_address, write, virtual_address_w, accesstag_w, phys_w,
    input  miss, done, accesstag_r, phys_r
  );
  modport slave (
    input  enable, invalidate, resolve, virtual_address, write, virtual_address_w, accesstag_w, phys_w,
    output miss, done, accesstag_r, phys_r
  );
endinterface

// File: rtl/armleocpu_tlb_way.sv
// armleocpu_tlb_way: one direct-mapped TLB way with one-cycle resolve and single-cycle flush
module armleocpu_tlb_way #(
  parameter int ENTRIES_W = 4,
  parameter int WAY_NUM   = 0
) (
  input logic               clk,
  input logic               rst_n,
  armleocpu_tlb_way_if.slave bus
);
  localparam int N  = 2**ENTRIES_W;
  localparam int TW = 20 - ENTRIES_W;
  localparam logic [31:0] WAY_ID = 32'(WAY_NUM);
  logic                 unused_way;
  logic [N-1:0]         valid;
  logic [TW-1:0]        tag  [N];
  logic [7:0]           acc  [N];
  logic [21:0]          phys [N];
  logic [ENTRIES_W-1:0] idx, widx;
  logic                 hit, do_inv, do_res, do_wr;
  assign unused_way = WAY_ID[0];
  assign idx    = bus.virtual_address[ENTRIES_W-1:0];
  assign widx   = bus.virtual_address_w[ENTRIES_W-1:0];
  assign hit    = valid[idx] && tag[idx] == bus.virtual_address[19:ENTRIES_W];
  assign do_inv = bus.enable && bus.invalidate;
  assign do_res = bus.enable && bus.resolve && !bus.invalidate;
  assign do_wr  = bus.enable && bus.write && !bus.invalidate && !bus.resolve;
  // valid bits live in flops so a flush clears every entry in one edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid           <= '0;
      bus.done        <= 1'b0;
      bus.miss        <= 1'b0;
      bus.accesstag_r <= '0;
      bus.phys_r      <= '0;
    end else begin
      valid    <= do_inv ? '0 : do_wr ? (valid | (N'(1) << widx)) : valid;
      bus.done <= do_inv || do_res;
      bus.miss <= do_res && !hit;
      if (do_res) begin
        bus.accesstag_r <= acc[idx];
        bus.phys_r      <= phys[idx];
      end
    end
  always_ff @(posedge clk)
    if (do_wr) begin
      tag[widx]  <= bus.virtual_address_w[19:ENTRIES_W];
      acc[widx]  <= bus.accesstag_w;
      phys[widx] <= bus.phys_w;
    end
endmodule

// File: tb/tb_armleocpu_tlb_way.sv
// tb_armleocpu_tlb_way: directed scoreboard bench for one TLB way
module tb_armleocpu_tlb_way;
  typedef struct {
    string       tag;
    logic        done;
    logic        miss;
    logic        chk;
    logic [7:0]  acc;
    logic [21:0] phys;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  armleocpu_tlb_way_if bus ();
  armleocpu_tlb_way #(.ENTRIES_W(4), .WAY_NUM(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cmd(input logic en, input logic inv, input logic res, input logic [19:0] va,
                     input logic wr, input logic [19:0] vaw, input logic [7:0] aw, input logic [21:0] pw,
                     input string tag, input logic d, input logic m, input logic c,
                     input logic [7:0] a, input logic [21:0] p);
    exp_t e;
    bus.enable = en; bus.invalidate = inv; bus.resolve = res; bus.virtual_address = va;
    bus.write = wr; bus.virtual_address_w = vaw; bus.accesstag_w = aw; bus.phys_w = pw;
    q.push_back('{tag, d, m, c, a, p});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check({e.tag, ".done"}, 32'(bus.done), 32'(e.done));
      check({e.tag, ".miss"}, 32'(bus.miss), 32'(e.miss));
      if (e.chk) begin
        check({e.tag, ".acc"}, 32'(bus.accesstag_r), 32'(e.acc));
        check({e.tag, ".phys"}, 32'(bus.phys_r), 32'(e.phys));
      end
    end
  endtask
  task automatic idle(input string tag);
    cmd(1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 20'h0, 8'h0, 22'h0, tag, 1'b0, 1'b0, 1'b0, 8'h0, 22'h0);
  endtask
  task automatic res(input logic [19:0] va, input string tag, input logic m, input logic c,
                     input logic [7:0] a, input logic [21:0] p);
    cmd(1'b1, 1'b0, 1'b1, va, 1'b0, 20'h0, 8'h0, 22'h0, tag, 1'b1, m, c, a, p);
  endtask
  task automatic wr(input logic [19:0] vaw, input logic [7:0] aw, input logic [21:0] pw, input string tag);
    cmd(1'b1, 1'b0, 1'b0, 20'h0, 1'b1, vaw, aw, pw, tag, 1'b0, 1'b0, 1'b0, 8'h0, 22'h0);
  endtask
  function automatic logic [19:0] fill_va(input int i);
    return {16'(i * 3 + 16'h0A07), 4'(i)};
  endfunction
  initial begin
    bus.enable = 0; bus.invalidate = 0; bus.resolve = 0; bus.virtual_address = 0;
    bus.write = 0; bus.virtual_address_w = 0; bus.accesstag_w = 0; bus.phys_w = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.miss", 32'(bus.miss), 32'd0);
    check("rst.acc", 32'(bus.accesstag_r), 32'd0);
    check("rst.phys", 32'(bus.phys_r), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    res(20'h00012, "t1.res", 1'b1, 1'b0, 8'h0, 22'h0);
    idle("t1.idle");
    wr(20'h12345, 8'hCF, 22'h2ABCDE, "t2.wr");
    res(20'h12345, "t2.hit", 1'b0, 1'b1, 8'hCF, 22'h2ABCDE);
    idle("t2.idle");
    res(20'h02345, "t3.alias", 1'b1, 1'b0, 8'h0, 22'h0);
    cmd(1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 20'h0, 8'h0, 22'h0, "t4.inv", 1'b1, 1'b0, 1'b1, 8'hCF, 22'h2ABCDE);
    res(20'h12345, "t4.after", 1'b1, 1'b0, 8'h0, 22'h0);
    cmd(1'b1, 1'b0, 1'b1, 20'h11111, 1'b1, 20'h11111, 8'h55, 22'h111111, "t5.wr_res", 1'b1, 1'b1, 1'b0, 8'h0, 22'h0);
    res(20'h11111, "t5.dropped", 1'b1, 1'b0, 8'h0, 22'h0);
    cmd(1'b1, 1'b1, 1'b1, 20'h11111, 1'b0, 20'h0, 8'h0, 22'h0, "t5.inv_res", 1'b1, 1'b0, 1'b0, 8'h0, 22'h0);
    cmd(1'b0, 1'b0, 1'b1, 20'h00012, 1'b0, 20'h0, 8'h0, 22'h0, "t5.en0_res", 1'b0, 1'b0, 1'b0, 8'h0, 22'h0);
    cmd(1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 20'h22222, 8'h66, 22'h222222, "t5.en0_wr", 1'b0, 1'b0, 1'b0, 8'h0, 22'h0);
    res(20'h22222, "t5.en0_miss", 1'b1, 1'b0, 8'h0, 22'h0);
    for (int i = 0; i < 16; i++)
      wr(fill_va(i), 8'(8'h10 + i), 22'(22'h100000 + i * 22'h111), $sformatf("t6.wr%0d", i));
    for (int i = 0; i < 16; i++)
      res(fill_va(i), $sformatf("t6.hit%0d", i), 1'b0, 1'b1, 8'(8'h10 + i), 22'(22'h100000 + i * 22'h111));
    for (int i = 0; i < 16; i++) begin
      res(fill_va(i), $sformatf("t6.b%0d", i), i >= 9, i < 9, 8'(8'h10 + i), 22'(22'h100000 + i * 22'h111));
      if (i == 8) begin
        rst_n = 1'b0;
        #1;
        check("t6.rst.done", 32'(bus.done), 32'd0);
        check("t6.rst.miss", 32'(bus.miss), 32'd0);
        check("t6.rst.phys", 32'(bus.phys_r), 32'd0);
        @(negedge clk) rst_n = 1'b1;
      end
    end
    idle("t6.idle");
    check("queue_left", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    check("timeout", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
